crc32_dn_check: RTL and testbench



---
 rtl/crc32_dn_check.sv | 86 ++++++++
 tb/tb_crc32_dn_check.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc32_dn_check.sv
// crc32_dn_check: receive-side Ethernet FCS checker, CRC-32 residue test.
// Ports: clk, rst (sync, high); data/bnum/valid/eof beat in; err pulse out.
// Optional CRC32_CHECK_OK_EN adds output ok (good-frame pulse).
module crc32_dn_check #(
   parameter int NUM = 4,
   localparam int BW = (NUM > 1) ? $clog2(NUM) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [8*NUM-1:0] data,
   input  logic [BW-1:0]    bnum,
   input  logic             valid,
   input  logic             eof,
`ifdef CRC32_CHECK_OK_EN
   output logic             ok,
`endif
   output logic             err
);

   localparam logic [31:0] POLY  = 32'hEDB88320;
   localparam logic [31:0] INIT  = 32'hFFFFFFFF;
   localparam logic [31:0] RESID = 32'hDEBB20E3;

   logic [31:0] crc_q;
   logic [31:0] crc_d;
   logic        err_q;
   logic        match;
   int          nlanes;

   function automatic logic [31:0] crc_byte(
      input logic [31:0] c,
      input logic [7:0]  b
   );
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) begin
         r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
      end
      return r;
   endfunction

   // Lane 0 of the fold is the MSB lane; on eof only the
   // first nlanes lanes count, bnum==0 meaning all of them.
   always_comb begin
      nlanes = NUM;
      if (NUM > 1 && eof && bnum != '0) begin
         nlanes = int'(bnum);
      end
      crc_d = crc_q;
      for (int i = 0; i < NUM; i++) begin
         if (i < nlanes) begin
            crc_d = crc_byte(crc_d, data[8*(NUM-1-i) +: 8]);
         end
      end
      match = (crc_d == RESID);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         crc_q <= INIT;
         err_q <= 1'b0;
      end else begin
         err_q <= valid & eof & ~match;
         if (valid) begin
            crc_q <= eof ? INIT : crc_d;
         end
      end
   end

`ifdef CRC32_CHECK_OK_EN
   logic ok_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ok_q <= 1'b0;
      end else begin
         ok_q <= valid & eof & match;
      end
   end

   assign ok = ok_q;
`endif

   assign err = err_q;

endmodule

// File: tb/tb_crc32_dn_check.sv
// tb_crc32_dn_check: directed frames into NUM=4 and NUM=1 checkers.
// Expected err per frame comes from the vector table.
module tb_crc32_dn_check;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data4;
   logic [1:0]  bnum4;
   logic        valid4;
   logic        eof4;
   logic        err4;
   logic [7:0]  data1;
   logic [0:0]  bnum1;
   logic        valid1;
   logic        eof1;
   logic        err1;
`ifdef CRC32_CHECK_OK_EN
   logic        ok4;
   logic        ok1;
`endif

   int errs = 0;
   int checks = 0;

   logic [7:0] fb [0:127];
   int         total;

   always #5 clk = ~clk;

   crc32_dn_check #(.NUM(4)) u_dut4 (
      .clk   (clk),
      .rst   (rst),
      .data  (data4),
      .bnum  (bnum4),
      .valid (valid4),
      .eof   (eof4),
`ifdef CRC32_CHECK_OK_EN
      .ok    (ok4),
`endif
      .err   (err4)
   );

   crc32_dn_check #(.NUM(1)) u_dut1 (
      .clk   (clk),
      .rst   (rst),
      .data  (data1),
      .bnum  (bnum1),
      .valid (valid1),
      .eof   (eof1),
`ifdef CRC32_CHECK_OK_EN
      .ok    (ok1),
`endif
      .err   (err1)
   );

   typedef struct {
      int   sel;
      int   kind;
      int   len;
      int   pos;
      int   tog;
      int   garb;
      int   idle;
      logic exp;
   } vec_t;

   vec_t vecs [16];

   function automatic logic [31:0] crc_upd(
      input logic [31:0] c,
      input logic [7:0]  b
   );
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) begin
         if (r[0]) r = (r >> 1) ^ 32'hEDB88320;
         else      r = r >> 1;
      end
      return r;
   endfunction

   task automatic chk(
      input string nm,
      input int    vi,
      input logic  got,
      input logic  exp
   );
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL vec%0d %s got=%b want=%b t=%0t",
                  vi, nm, got, exp, $time);
      end
   endtask

   // kind 0 good, 1 invert last 4 bytes, 2 flip one bit,
   // 3 "123456789" with its published FCS
   task automatic build(
      input int kind,
      input int len,
      input int pos
   );
      logic [31:0] c;
      logic [7:0]  m;
      if (kind == 3) begin
         for (int i = 0; i < 9; i++) fb[i] = 8'(8'h31 + i);
         fb[9]  = 8'h26;
         fb[10] = 8'h39;
         fb[11] = 8'hF4;
         fb[12] = 8'hCB;
         total = 13;
      end else begin
         c = 32'hFFFFFFFF;
         for (int i = 0; i < len; i++) begin
            fb[i] = 8'((i * 37 + 11) & 255);
            c = crc_upd(c, fb[i]);
         end
         c = ~c;
         fb[len]   = c[7:0];
         fb[len+1] = c[15:8];
         fb[len+2] = c[23:16];
         fb[len+3] = c[31:24];
         total = len + 4;
         if (kind == 1) begin
            for (int i = total - 4; i < total; i++) fb[i] = ~fb[i];
         end
         if (kind == 2) begin
            m = 8'(1 << (pos % 8));
            fb[pos] = fb[pos] ^ m;
         end
      end
   endtask

   task automatic tick(
      input int   vi,
      input int   sel,
      input bit   last,
      input logic exp
   );
      logic e4, e1;
      e4 = (sel == 4 && last) ? exp : 1'b0;
      e1 = (sel == 1 && last) ? exp : 1'b0;
      @(posedge clk);
      #1;
      chk("err4", vi, err4, e4);
      chk("err1", vi, err1, e1);
`ifdef CRC32_CHECK_OK_EN
      chk("ok4", vi, ok4, sel == 4 && last && !exp);
      chk("ok1", vi, ok1, sel == 1 && last && !exp);
`endif
   endtask

   task automatic idle(input int vi, input bit eofv);
      valid4 = 1'b0;
      valid1 = 1'b0;
      eof4   = eofv;
      eof1   = eofv;
      data4  = $urandom;
      data1  = 8'($urandom);
      tick(vi, 0, 1'b0, 1'b0);
   endtask

   task automatic drive_beat(
      input int sel,
      input int b,
      input bit garb,
      input bit last
   );
      int         idx;
      logic [7:0] v;
      if (sel == 4) begin
         for (int l = 0; l < 4; l++) begin
            idx = b * 4 + l;
            if (idx < total)  v = fb[idx];
            else if (garb)    v = 8'($urandom);
            else              v = 8'h00;
            data4[8*(3-l) +: 8] = v;
         end
         bnum4  = last ? 2'(total % 4) : 2'(b);
         valid4 = 1'b1;
         eof4   = last;
         valid1 = 1'b0;
         eof1   = 1'b0;
      end else begin
         data1  = fb[b];
         bnum1  = 1'(b);
         valid1 = 1'b1;
         eof1   = last;
         valid4 = 1'b0;
         eof4   = 1'b0;
      end
   endtask

   task automatic send(input int vi, input vec_t v);
      int nb;
      bit last;
      nb = (v.sel == 4) ? (total + 3) / 4 : total;
      for (int b = 0; b < nb; b++) begin
         if (v.tog != 0 && b % 2 == 1) idle(vi, 1'b1);
         last = (b == nb - 1);
         drive_beat(v.sel, b, v.garb != 0, last);
         tick(vi, v.sel, last, last ? v.exp : 1'b0);
      end
   endtask

   initial begin
      vecs[0]  = '{4, 3,  9,  0, 0, 0, 0, 1'b0};
      vecs[1]  = '{4, 0, 84,  0, 0, 0, 1, 1'b0};
      vecs[2]  = '{4, 1, 84,  0, 0, 0, 1, 1'b1};
      vecs[3]  = '{4, 0, 84,  0, 0, 0, 1, 1'b0};
      vecs[4]  = '{4, 0, 60,  0, 0, 0, 0, 1'b0};
      vecs[5]  = '{4, 0, 79,  0, 0, 1, 0, 1'b0};
      vecs[6]  = '{4, 0,  0,  0, 0, 0, 0, 1'b0};
      vecs[7]  = '{4, 0,  2,  0, 0, 1, 1, 1'b0};
      vecs[8]  = '{4, 0, 84,  0, 1, 0, 0, 1'b0};
      vecs[9]  = '{4, 2, 84,  5, 0, 0, 0, 1'b1};
      vecs[10] = '{4, 2, 84, 86, 0, 1, 0, 1'b1};
      vecs[11] = '{1, 0, 84,  0, 0, 0, 1, 1'b0};
      vecs[12] = '{1, 1, 84,  0, 0, 0, 1, 1'b1};
      vecs[13] = '{1, 0, 84,  0, 1, 0, 0, 1'b0};
      vecs[14] = '{1, 2, 84, 40, 0, 0, 0, 1'b1};
      vecs[15] = '{1, 3,  9,  0, 0, 0, 0, 1'b0};

      rst    = 1'b1;
      data4  = '0;
      bnum4  = '0;
      valid4 = 1'b0;
      eof4   = 1'b0;
      data1  = '0;
      bnum1  = '0;
      valid1 = 1'b0;
      eof1   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_err4", 99, err4, 1'b0);
      chk("rst_err1", 99, err1, 1'b0);
`ifdef CRC32_CHECK_OK_EN
      chk("rst_ok4", 99, ok4, 1'b0);
      chk("rst_ok1", 99, ok1, 1'b0);
`endif
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         build(vecs[i].kind, vecs[i].len, vecs[i].pos);
         if (vecs[i].idle != 0) idle(i, 1'b0);
         send(i, vecs[i]);
      end
      idle(50, 1'b0);

      // Abort a frame with reset; the reset cycle also carries
      // a valid eof on partial data, which must not flag.
      build(0, 84, 0);
      for (int b = 0; b < 10; b++) begin
         drive_beat(4, b, 1'b0, 1'b0);
         tick(60, 4, 1'b0, 1'b0);
      end
      drive_beat(4, 10, 1'b0, 1'b1);
      rst = 1'b1;
      tick(61, 4, 1'b0, 1'b0);
      rst = 1'b0;
      send(62, vecs[1]);

      // Same abort on the byte-serial checker.
      for (int b = 0; b < 7; b++) begin
         drive_beat(1, b, 1'b0, 1'b0);
         tick(63, 1, 1'b0, 1'b0);
      end
      drive_beat(1, 7, 1'b0, 1'b1);
      rst = 1'b1;
      tick(64, 1, 1'b0, 1'b0);
      rst = 1'b0;
      send(65, vecs[11]);
      idle(66, 1'b0);
      idle(67, 1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
